seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a common-segment 7-segment display bank. It holds a display value and a per-digit enable mask, and steps through the digits at a programmable rate. For each digit it drives one shared `Seg7Decoder` instance and asserts the matching digit-select line. New values arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned value updates
// Holds an active and a pending display set; the pending set is promoted only at frame boundaries.

module seg7_decoder (
    input  logic [3:0] i_hex,
    input  logic       i_en,
    output logic [6:0] o_seg
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        o_seg = 7'b1111111;
        if (i_en) begin
            case (i_hex)
                4'h0: o_seg = 7'b1000000;
                4'h1: o_seg = 7'b1111001;
                4'h2: o_seg = 7'b0100100;
                4'h3: o_seg = 7'b0110000;
                4'h4: o_seg = 7'b0011001;
                4'h5: o_seg = 7'b0010010;
                4'h6: o_seg = 7'b0000010;
                4'h7: o_seg = 7'b1111000;
                4'h8: o_seg = 7'b0000000;
                4'h9: o_seg = 7'b0010000;
                4'hA: o_seg = 7'b0001000;
                4'hB: o_seg = 7'b0000011;
                4'hC: o_seg = 7'b1000110;
                4'hD: o_seg = 7'b0100001;
                4'hE: o_seg = 7'b0000110;
                default: o_seg = 7'b0001110;
            endcase
        end
    end
endmodule

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [4*NUM_DIGITS-1:0] i_in_data,
    input  logic [NUM_DIGITS-1:0]   i_in_mask,
    input  logic                    i_in_blank_lz,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_frame_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_mask;
    logic                    r_act_blank_lz;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_mask;
    logic                    r_pend_blank_lz;
    logic                    r_pend_v;

    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_accept;
    logic [3:0]              w_nibble;
    logic                    w_upper_zero;
    logic                    w_blank;
    logic                    w_lit;
    logic [6:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_tick     = (r_cnt == CW'(DIV - 1));
    assign w_boundary = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign o_in_ready = !r_pend_v;
    assign w_accept   = i_in_valid && !r_pend_v;
    assign w_nibble   = r_act_data[r_idx*4 +: 4];

    // Current digit is a leading zero when it and every more significant nibble are zero
    always_comb begin
        w_upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(r_idx) && r_act_data[4*k +: 4] != 4'h0)
                w_upper_zero = 1'b0;
        end
    end

    assign w_blank   = r_act_blank_lz && w_upper_zero && (r_idx != '0);
    assign w_lit     = r_act_mask[r_idx] && !w_blank;
    assign w_an_next = w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;

    seg7_decoder u_dec (
        .i_hex (w_nibble),
        .i_en  (w_lit),
        .o_seg (w_dec_seg)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt           <= '0;
            r_idx           <= '0;
            r_act_data      <= '0;
            r_act_mask      <= '0;
            r_act_blank_lz  <= 1'b0;
            r_pend_data     <= '0;
            r_pend_mask     <= '0;
            r_pend_blank_lz <= 1'b0;
            r_pend_v        <= 1'b0;
            o_an            <= '1;
            o_seg           <= 7'b1111111;
            o_frame_done    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // An accept on an idle boundary bypasses the pending set
            if (w_boundary && r_pend_v) begin
                r_act_data     <= r_pend_data;
                r_act_mask     <= r_pend_mask;
                r_act_blank_lz <= r_pend_blank_lz;
                r_pend_v       <= 1'b0;
            end else if (w_boundary && w_accept) begin
                r_act_data     <= i_in_data;
                r_act_mask     <= i_in_mask;
                r_act_blank_lz <= i_in_blank_lz;
            end else if (w_accept) begin
                r_pend_data     <= i_in_data;
                r_pend_mask     <= i_in_mask;
                r_pend_blank_lz <= i_in_blank_lz;
                r_pend_v        <= 1'b1;
            end

            o_an         <= w_an_next;
            o_seg        <= w_dec_seg;
            o_frame_done <= w_boundary;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl against a frame-level model

module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int DV    = 4;
    localparam int FRAME = ND * DV;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_mask;
    logic        in_blank_lz;
    logic        in_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .i_in_mask     (in_mask),
        .i_in_blank_lz (in_blank_lz),
        .o_an          (an),
        .o_seg         (seg),
        .o_frame_done  (frame_done)
    );

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: cycles since reset, displayed set, waiting set, expected registered outputs
    int          m_cycle;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_mask, p_mask;
    logic        m_blz, p_blz, m_pv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic digit_lit(input int k);
        logic blank;
        blank = m_blz && (k != 0) && ((m_data >> (4 * k)) == 16'h0);
        return m_mask[k] && !blank;
    endfunction

    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic [3:0] mk, input logic b);
        logic       acc, bnd, lit;
        int         idx;
        logic [3:0] nib;
        rst = r; in_valid = v; in_data = d; in_mask = mk; in_blank_lz = b;
        acc = v && !m_pv && !r;
        idx = (m_cycle / DV) % ND;
        bnd = (m_cycle % FRAME) == FRAME - 1;
        @(posedge clk);
        if (r) begin
            m_cycle = 0; m_data = '0; m_mask = '0; m_blz = 0; m_pv = 0;
            p_data = '0; p_mask = '0; p_blz = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
        end else begin
            lit   = digit_lit(idx);
            nib   = 4'(m_data >> (4 * idx));
            e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            e_seg = lit ? seg_tbl[nib] : 7'h7F;
            e_fd  = bnd;
            if (bnd && m_pv) begin
                m_data = p_data; m_mask = p_mask; m_blz = p_blz; m_pv = 0;
            end else if (bnd && acc) begin
                m_data = d; m_mask = mk; m_blz = b;
            end else if (acc) begin
                p_data = d; p_mask = mk; p_blz = b; m_pv = 1;
            end
            m_cycle++;
        end
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("frame_done", frame_done, e_fd);
        chk("in_ready", in_ready, !m_pv);
        chk("an_onecold", $countones(~an) <= 1, 1);
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 4'h0, 0);
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] mk, input logic b,
                         output int acc_at);
        logic rdy;
        acc_at = -1;
        for (int i = 0; i < 64; i++) begin
            rdy = !m_pv;
            step(0, 1, d, mk, b);
            if (rdy) begin
                acc_at = m_cycle;
                break;
            end
        end
        if (acc_at < 0) chk("offer_timeout", 0, 1);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 64 && (m_cycle % FRAME) != phase; i++) idle();
        chk("phase_reached", m_cycle % FRAME, phase);
    endtask

    task automatic frame_expect(input string tag, input logic [15:0] exp_an, input logic [27:0] exp_seg);
        idle_until(0);
        for (int dg = 0; dg < ND; dg++) begin
            for (int j = 0; j < DV; j++) begin
                idle();
                if (j == 0) begin
                    chk({tag, "_an"}, an, exp_an[dg*4 +: 4]);
                    chk({tag, "_seg"}, seg, exp_seg[dg*7 +: 7]);
                end
            end
        end
    endtask

    initial begin
        int acc_at;
        int pulses;
        m_cycle = 0; m_pv = 0; m_data = '0; m_mask = '0; m_blz = 0;

        repeat (3) step(1, 0, 16'h0, 4'h0, 0);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_ready", in_ready, 1);
        chk("rst_fd", frame_done, 0);

        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            idle();
            if (frame_done) pulses++;
        end
        chk("fd_pulses", pulses, 2);
        chk("idle_an", an, 4'b1111);

        offer(16'h0123, 4'hF, 0, acc_at);
        frame_expect("basic", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                     {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});

        offer(16'h0005, 4'hF, 1, acc_at);
        frame_expect("blank5", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                     {7'h7F, 7'h7F, 7'h7F, 7'b0010010});

        offer(16'h0000, 4'hF, 1, acc_at);
        frame_expect("blank0", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                     {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

        offer(16'hABCD, 4'b0101, 0, acc_at);
        frame_expect("mask", {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                     {7'h7F, 7'b0000011, 7'h7F, 7'b0100001});

        repeat (5) idle();
        offer(16'h1111, 4'hF, 0, acc_at);
        idle();
        chk("bp_ready_drop", in_ready, 0);
        offer(16'h2222, 4'hF, 0, acc_at);
        chk("bp_accept_phase", acc_at % FRAME, 1);
        frame_expect("bp_b", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                     {4{7'b0100100}});

        idle_until(FRAME - 1);
        step(0, 1, 16'h7777, 4'hF, 0);
        chk("bnd_ready", in_ready, 1);
        frame_expect("bnd_x", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                     {4{7'b1111000}});

        offer(16'h3333, 4'hF, 0, acc_at);
        idle_until(9);
        step(1, 0, 16'h0, 4'h0, 0);
        chk("midrst_an", an, 4'b1111);
        chk("midrst_ready", in_ready, 1);
        frame_expect("midrst_dark", 16'hFFFF, {4{7'h7F}});

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 16'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
